// File: rtl/serial_pkg.sv
// ============================================================================
// Module      : serial_pkg
// Description : Shared decoder index codes, status bit positions and UART
//               state encodings for the serial-port device path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_pkg;

    localparam logic [2:0] RAM                = 3'b000;
    localparam logic [2:0] SERIALPORT_DATA_1  = 3'b010;
    localparam logic [2:0] SERIALPORT_STATE_1 = 3'b011;
    localparam logic [2:0] SERIALPORT_DATA_2  = 3'b110;
    localparam logic [2:0] SERIALPORT_STATE_2 = 3'b111;

    localparam int STAT_TX_READY = 0;
    localparam int STAT_RX_READY = 1;
    localparam int STAT_OVERRUN  = 2;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module      : uart_rx_fifo
// Description : Receive byte buffer, either a single holding register
//               (DEPTH=1) or a 4-entry FIFO (DEPTH=4); pop-before-push.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);

    logic w_do_push;
    logic w_do_pop;

    // A pop in the same cycle frees the slot, so a full buffer still accepts
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || pop);

    generate
        if (DEPTH == 1) begin : g_single
            logic [7:0] r_data;
            logic       r_valid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data  <= 8'h00;
                    r_valid <= 1'b0;
                end else if (w_do_push) begin
                    r_data  <= din;
                    r_valid <= 1'b1;
                end else if (w_do_pop) begin
                    r_valid <= 1'b0;
                end
            end

            assign full  = r_valid;
            assign empty = !r_valid;
            assign head  = r_data;
        end else begin : g_multi
            localparam int                c_AW    = $clog2(DEPTH);
            localparam logic [c_AW-1:0]   c_P_ONE = c_AW'(1);
            localparam logic [c_AW:0]     c_C_ONE = (c_AW + 1)'(1);
            localparam logic [c_AW:0]     c_FULL  = (c_AW + 1)'(DEPTH);

            logic [7:0]      r_mem [DEPTH];
            logic [c_AW-1:0] r_rd_ptr;
            logic [c_AW-1:0] r_wr_ptr;
            logic [c_AW:0]   r_count;

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_mem[i] <= 8'h00;
                    end
                    r_rd_ptr <= '0;
                    r_wr_ptr <= '0;
                    r_count  <= '0;
                end else begin
                    if (w_do_push) begin
                        r_mem[r_wr_ptr] <= din;
                        r_wr_ptr        <= r_wr_ptr + c_P_ONE;
                    end
                    if (w_do_pop) begin
                        r_rd_ptr <= r_rd_ptr + c_P_ONE;
                    end
                    case ({w_do_push, w_do_pop})
                        2'b10:   r_count <= r_count + c_C_ONE;
                        2'b01:   r_count <= r_count - c_C_ONE;
                        default: r_count <= r_count;
                    endcase
                end
            end

            assign full  = (r_count == c_FULL);
            assign empty = (r_count == '0);
            assign head  = r_mem[r_rd_ptr];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/uart_mmio_port.sv
// ============================================================================
// Module      : uart_mmio_port
// Description : Memory-mapped 8N1 UART (data + status registers) behind the
//               address decoder. UART_RX_FIFO_EN selects a 4-entry RX FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_mmio_port
    import serial_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [2:0] IDX_DATA     = SERIALPORT_DATA_2,
    parameter logic [2:0] IDX_STATE    = SERIALPORT_STATE_2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  idx,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    output logic [15:0] rd_data,
    input  logic        uart_rxd,
    output logic        uart_txd
);

`ifdef UART_RX_FIFO_EN
    localparam int c_FIFO_DEPTH = 4;
`else
    localparam int c_FIFO_DEPTH = 1;
`endif

    localparam int              c_CW       = $clog2(CLKS_PER_BIT);
    localparam logic [c_CW-1:0] c_BIT_LAST = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_CW-1:0] c_HALF_LAST = c_CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

    logic w_data_sel, w_state_sel;
    logic w_wr_accept, w_pop, w_stat_rd;
    logic w_tx_ready;

    assign w_data_sel  = (idx == IDX_DATA);
    assign w_state_sel = (idx == IDX_STATE);
    assign w_wr_accept = wr_en && w_data_sel && w_tx_ready;
    assign w_pop       = rd_en && w_data_sel;
    assign w_stat_rd   = rd_en && w_state_sel;

    // ------------------------------------------------------------------ TX
    tx_state_t       r_tx_state, w_tx_next;
    logic [c_CW-1:0] r_tx_cnt;
    logic [2:0]      r_tx_bit;
    logic [7:0]      r_tx_shift;
    logic            w_tx_tick;

    assign w_tx_tick = (r_tx_cnt == c_BIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) r_tx_state <= TX_IDLE;
        else     r_tx_state <= w_tx_next;
    end

    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            TX_IDLE:  if (w_wr_accept) w_tx_next = TX_START;
            TX_START: if (w_tx_tick) w_tx_next = TX_DATA;
            TX_DATA:  if (w_tx_tick && (r_tx_bit == 3'd7)) w_tx_next = TX_STOP;
            TX_STOP:  if (w_tx_tick) w_tx_next = TX_IDLE;
            default:  w_tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        uart_txd   = 1'b1;
        w_tx_ready = 1'b0;
        case (r_tx_state)
            TX_IDLE:  w_tx_ready = 1'b1;
            TX_START: uart_txd   = 1'b0;
            TX_DATA:  uart_txd   = r_tx_shift[0];
            default:  uart_txd   = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= 8'h00;
        end else if (r_tx_state == TX_IDLE) begin
            r_tx_cnt <= '0;
            r_tx_bit <= 3'd0;
            if (w_wr_accept) r_tx_shift <= wr_data;
        end else if (w_tx_tick) begin
            r_tx_cnt <= '0;
            if (r_tx_state == TX_DATA) begin
                r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                r_tx_bit   <= r_tx_bit + 3'd1;
            end
        end else begin
            r_tx_cnt <= r_tx_cnt + c_CNT_ONE;
        end
    end

    // ------------------------------------------------------------------ RX
    rx_state_t       r_rx_state, w_rx_next;
    logic            r_rxd_meta, r_rxd_sync, r_rxd_prev;
    logic [c_CW-1:0] r_rx_cnt;
    logic [2:0]      r_rx_bit;
    logic [7:0]      r_rx_shift;
    logic            w_rx_tick, w_rx_half, w_rx_restart, w_rx_push;

    assign w_rx_tick = (r_rx_cnt == c_BIT_LAST);
    assign w_rx_half = (r_rx_cnt == c_HALF_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
            r_rxd_prev <= 1'b1;
        end else begin
            r_rxd_meta <= uart_rxd;
            r_rxd_sync <= r_rxd_meta;
            r_rxd_prev <= r_rxd_sync;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_rx_state <= RX_IDLE;
        else     r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  if (r_rxd_prev && !r_rxd_sync) w_rx_next = RX_START;
            RX_START: if (w_rx_half) w_rx_next = r_rxd_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_rx_tick && (r_rx_bit == 3'd7)) w_rx_next = RX_STOP;
            RX_STOP:  if (w_rx_tick) w_rx_next = RX_IDLE;
            default:  w_rx_next = RX_IDLE;
        endcase
    end

    // Only a high stop bit delivers the byte; a low one is a framing error
    always_comb begin
        w_rx_push    = 1'b0;
        w_rx_restart = 1'b0;
        case (r_rx_state)
            RX_START: w_rx_restart = w_rx_half;
            RX_DATA:  w_rx_restart = w_rx_tick;
            RX_STOP: begin
                w_rx_restart = w_rx_tick;
                w_rx_push    = w_rx_tick && r_rxd_sync;
            end
            default: w_rx_restart = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'h00;
        end else if (r_rx_state == RX_IDLE) begin
            r_rx_cnt <= '0;
            r_rx_bit <= 3'd0;
        end else if (w_rx_restart) begin
            r_rx_cnt <= '0;
            if (r_rx_state == RX_DATA) begin
                r_rx_shift <= {r_rxd_sync, r_rx_shift[7:1]};
                r_rx_bit   <= r_rx_bit + 3'd1;
            end
        end else begin
            r_rx_cnt <= r_rx_cnt + c_CNT_ONE;
        end
    end

    // ------------------------------------------------------- buffer/status
    logic       w_fifo_full, w_fifo_empty;
    logic [7:0] w_rx_byte;
    logic       r_overrun;

    uart_rx_fifo #(
        .DEPTH (c_FIFO_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_rx_push),
        .pop   (w_pop),
        .din   (r_rx_shift),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .head  (w_rx_byte)
    );

    // A drop in the same cycle as a status read still latches
    always_ff @(posedge clk) begin
        if (rst)                                          r_overrun <= 1'b0;
        else if (w_rx_push && w_fifo_full && !w_pop)      r_overrun <= 1'b1;
        else if (w_stat_rd)                               r_overrun <= 1'b0;
    end

    always_comb begin
        rd_data = 16'h0000;
        if (w_data_sel) begin
            rd_data = {8'h00, w_rx_byte};
        end else if (w_state_sel) begin
            rd_data[STAT_TX_READY] = w_tx_ready;
            rd_data[STAT_RX_READY] = !w_fifo_empty;
            rd_data[STAT_OVERRUN]  = r_overrun;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_mmio_port.sv
// ============================================================================
// Module      : tb_uart_mmio_port
// Description : Directed self-checking bench for uart_mmio_port at
//               CLKS_PER_BIT=4; honours UART_RX_FIFO_EN for overrun depth.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_mmio_port;

    localparam int c_CPB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  idx;
    logic        rd_en;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic [15:0] rd_data;
    logic        uart_rxd;
    logic        uart_txd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_mmio_port #(
        .CLKS_PER_BIT (c_CPB),
        .IDX_DATA     (3'b110),
        .IDX_STATE    (3'b111)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .idx      (idx),
        .rd_en    (rd_en),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .uart_rxd (uart_rxd),
        .uart_txd (uart_txd)
    );

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Combinational look at a register without a strobe
    task automatic peek(input logic [2:0] a, input logic [15:0] exp, input string tag);
        idx = a;
        #1;
        check_eq(tag, rd_data, exp);
    endtask

    task automatic bus_read(input logic [2:0] a, input logic [15:0] exp, input string tag);
        idx   = a;
        rd_en = 1'b1;
        #1;
        check_eq(tag, rd_data, exp);
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    // Write b, then check every bit cell of the frame; optionally try a
    // second write (8'h3C) in cycle 5 which must be dropped
    task automatic tx_frame(input logic [7:0] b, input bit inject);
        logic [9:0] frame;
        frame   = {1'b1, b, 1'b0};
        idx     = 3'b110;
        wr_data = b;
        wr_en   = 1'b1;
        for (int n = 1; n <= 10 * c_CPB; n++) begin
            @(negedge clk);
            wr_en = 1'b0;
            if (inject && n == 5) begin
                wr_data = 8'h3C;
                wr_en   = 1'b1;
            end
            #1;
            check_eq("tx_bit", {15'b0, uart_txd}, {15'b0, frame[(n - 1) / c_CPB]});
            if (n == 1 || n == 10 * c_CPB) begin
                peek(3'b111, 16'h0000, "tx_busy_status");
                idx = 3'b110;
            end
        end
        @(negedge clk);
        peek(3'b111, 16'h0001, "tx_ready_end");
        check_eq("tx_idle_line", {15'b0, uart_txd}, 16'h0001);
        idx = 3'b110;
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            uart_rxd = frame[k];
            repeat (c_CPB) @(negedge clk);
        end
        uart_rxd = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        idx      = 3'b000;
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        wr_data  = 8'h00;
        uart_rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        peek(3'b111, 16'h0001, "rst_status");
        check_eq("rst_txd", {15'b0, uart_txd}, 16'h0001);
        peek(3'b110, 16'h0000, "rst_data");
        peek(3'b000, 16'h0000, "other_idx");

        // Second frame is written back-to-back in the tx_ready cycle
        tx_frame(8'hA5, 1'b0);
        tx_frame(8'h3C, 1'b0);
        tx_frame(8'hA5, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            check_eq("no_dropped_frame", {15'b0, uart_txd}, 16'h0001);
        end

        // Reset while bit 1 (a zero) of 8'hA5 is on the line
        @(negedge clk);
        idx     = 3'b110;
        wr_data = 8'hA5;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        check_eq("pre_reset_txd", {15'b0, uart_txd}, 16'h0000);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("post_reset_txd", {15'b0, uart_txd}, 16'h0001);
        peek(3'b111, 16'h0001, "post_reset_status");

        // Receive path
        rx_frame(8'h5A, 1'b1);
        peek(3'b111, 16'h0003, "rx_ready");
        bus_read(3'b110, 16'h005A, "rx_data");
        peek(3'b111, 16'h0001, "rx_popped");

        uart_rxd = 1'b0;
        repeat (2) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (10) @(negedge clk);
        peek(3'b111, 16'h0001, "glitch_ignored");
        rx_frame(8'hFF, 1'b0);
        peek(3'b111, 16'h0001, "framing_error");
        rx_frame(8'hC3, 1'b1);
        peek(3'b110, 16'h00C3, "recover_data");
        bus_read(3'b110, 16'h00C3, "recover_pop");
        bus_read(3'b110, 16'h00C3, "pop_empty_data");
        peek(3'b111, 16'h0001, "pop_empty_status");

        // Overrun behaviour depends on buffer depth
        rx_frame(8'h11, 1'b1);
        rx_frame(8'h22, 1'b1);
`ifdef UART_RX_FIFO_EN
        peek(3'b111, 16'h0003, "fifo_two_no_ovr");
        rx_frame(8'h33, 1'b1);
        rx_frame(8'h44, 1'b1);
        peek(3'b111, 16'h0003, "fifo_four_no_ovr");
        rx_frame(8'h55, 1'b1);
        peek(3'b111, 16'h0007, "fifo_overrun");
        peek(3'b110, 16'h0011, "fifo_head_kept");
        bus_read(3'b111, 16'h0007, "ovr_clear_read");
        peek(3'b111, 16'h0003, "ovr_cleared");
        bus_read(3'b110, 16'h0011, "fifo_pop0");
        bus_read(3'b110, 16'h0022, "fifo_pop1");
        bus_read(3'b110, 16'h0033, "fifo_pop2");
        bus_read(3'b110, 16'h0044, "fifo_pop3");
        peek(3'b111, 16'h0001, "fifo_drained");
`else
        peek(3'b111, 16'h0007, "overrun");
        peek(3'b110, 16'h0011, "first_byte_kept");
        bus_read(3'b111, 16'h0007, "ovr_clear_read");
        peek(3'b111, 16'h0003, "ovr_cleared");
        bus_read(3'b110, 16'h0011, "held_pop");
        peek(3'b111, 16'h0001, "drained");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
